// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV64M multiply/divide unit.
//   One result bit per clock: shift-add multiply, restoring divide. Signed
//   operands are turned into magnitudes at capture and the sign is applied in
//   a single fix-up cycle. Divide-by-zero, signed overflow and illegal ops
//   skip the iteration states and complete two cycles after the start cycle.
// Ports:
//   clk, arst      clock, asynchronous active-high reset
//   i_start        request, sampled only when idle (i_flush high blocks it)
//   i_flush        abort any operation in flight, no done pulse
//   i_op           operation select (MUL..REMU, W variants)
//   i_src_1/2      rs1 / rs2
//   o_busy         high from the accepting edge until the done cycle ends
//   o_done         one-cycle completion pulse
//   o_result       result, held until the next completion
//   o_div_by_zero  qualifies o_done for divide/remainder by zero
module mdu_iterative #(
   parameter int DATA_WIDTH    = 64,
   parameter int WORD_WIDTH    = 32,
   parameter int CONTROL_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     i_start,
   input  logic                     i_flush,
   input  logic [CONTROL_WIDTH-1:0] i_op,
   input  logic [DATA_WIDTH-1:0]    i_src_1,
   input  logic [DATA_WIDTH-1:0]    i_src_2,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [DATA_WIDTH-1:0]    o_result,
   output logic                     o_div_by_zero
);
   localparam int DW = DATA_WIDTH;
   localparam int WW = WORD_WIDTH;
   localparam int CW = $clog2(DW) + 1;

   typedef enum logic [2:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FIX, S_DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      sel_q;
   logic            w_q, mul_q, sres_q, srem_q, spec_q, dbz_q;
   logic [DW-1:0]   a_q, b_q, spec_res_q;
   logic [2*DW-1:0] acc;   // mul: 2N product accumulator; div: {rem, quo}

   function automatic logic [DW-1:0] sext_w(input logic [DW-1:0] v);
      logic [DW-1:0] t;
      t = v << (DW - WW);
      return $signed(t) >>> (DW - WW);
   endfunction

   function automatic logic [DW-1:0] zext_w(input logic [DW-1:0] v);
      return v & ({DW{1'b1}} >> (DW - WW));
   endfunction

   // ---------------- operand decode / capture values ----------------
   logic [3:0]    op4;
   logic          is_w, is_mul, is_div, legal, sgn1, sgn2, neg1, neg2, dbz, ovf;
   logic [DW-1:0] ext1, ext2, mag1, mag2, min_neg, spec_res;

   always_comb begin
      op4    = i_op[3:0];
      is_w   = op4[3];
      is_mul = (op4[3:2] == 2'b00) || (op4 == 4'b1000);
      is_div = op4[2];
      legal  = (is_mul || is_div) && ((i_op >> 4) == '0);
      // MUL is done unsigned: the low half does not depend on signedness.
      // MULW must be signed so the multiplier magnitude fits in WW bits.
      sgn1 = is_mul ? (op4 == 4'b0001 || op4 == 4'b0010 || op4 == 4'b1000) : ~op4[0];
      sgn2 = is_mul ? (op4 == 4'b0001 || op4 == 4'b1000) : ~op4[0];
      ext1 = is_w ? (sgn1 ? sext_w(i_src_1) : zext_w(i_src_1)) : i_src_1;
      ext2 = is_w ? (sgn2 ? sext_w(i_src_2) : zext_w(i_src_2)) : i_src_2;
      neg1 = sgn1 & ext1[DW-1];
      neg2 = sgn2 & ext2[DW-1];
      mag1 = neg1 ? -ext1 : ext1;
      mag2 = neg2 ? -ext2 : ext2;
      min_neg = is_w ? sext_w(DW'(1) << (WW - 1)) : (DW'(1) << (DW - 1));
      dbz = legal && is_div && (ext2 == '0);
      ovf = legal && is_div && sgn1 && (ext1 == min_neg) && (ext2 == '1);
      if (!legal)   spec_res = '0;
      else if (dbz) spec_res = op4[1] ? (is_w ? sext_w(ext1) : ext1) : '1;
      else          spec_res = op4[1] ? '0 : ext1;
   end

   // ---------------- one iteration of each algorithm ----------------
   logic [DW:0]     mul_hi, div_hi, div_diff;
   logic [2*DW-1:0] mul_next, div_next;

   always_comb begin
      mul_hi   = b_q[0] ? ({1'b0, acc[2*DW-1:DW]} + {1'b0, a_q}) : {1'b0, acc[2*DW-1:DW]};
      mul_next = {mul_hi, acc[DW-1:1]};
      div_hi   = acc[2*DW-1:DW-1];          // remainder after the left shift
      div_diff = div_hi - {1'b0, a_q};
      div_next = div_diff[DW] ? {acc[2*DW-2:0], 1'b0}
                              : {div_diff[DW-1:0], acc[DW-2:0], 1'b1};
   end

   // ---------------- sign fix-up and result select ----------------
   logic [2*DW-1:0] prod;
   logic [DW-1:0]   quo, rem, fix_res;

   always_comb begin
      // a W multiply ran only WW iterations, so the product sits DW-WW bits high
      prod = w_q ? (acc >> (DW - WW)) : acc;
      if (sres_q) prod = -prod;
      quo = sres_q ? -acc[DW-1:0] : acc[DW-1:0];
      rem = srem_q ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
      if (mul_q) fix_res = (sel_q == 2'b00) ? prod[DW-1:0] : prod[2*DW-1:DW];
      else       fix_res = sel_q[1] ? rem : quo;
      if (w_q)    fix_res = sext_w(fix_res);
      if (spec_q) fix_res = spec_res_q;
   end

   // ---------------- control ----------------
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         sel_q         <= '0;
         w_q           <= 1'b0;
         mul_q         <= 1'b0;
         sres_q        <= 1'b0;
         srem_q        <= 1'b0;
         spec_q        <= 1'b0;
         dbz_q         <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         spec_res_q    <= '0;
         acc           <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_result      <= '0;
         o_div_by_zero <= 1'b0;
      end else if (state != S_IDLE && i_flush) begin
         state  <= S_IDLE;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (i_start && !i_flush) begin
               o_busy     <= 1'b1;
               sel_q      <= op4[1:0];
               w_q        <= is_w;
               mul_q      <= is_mul;
               sres_q     <= neg1 ^ neg2;
               srem_q     <= neg1;
               cnt        <= is_w ? CW'(WW - 1) : CW'(DW - 1);
               spec_q     <= !legal || dbz || ovf;
               dbz_q      <= dbz;
               spec_res_q <= spec_res;
               if (!legal || dbz || ovf) begin
                  // short-circuit: the fix-up cycle just publishes spec_res_q
                  state <= S_FIX;
               end else if (is_mul) begin
                  a_q   <= mag1;
                  b_q   <= mag2;
                  acc   <= '0;
                  state <= S_MUL_RUN;
               end else begin
                  a_q   <= mag2;
                  // left-align a W dividend so N shifts consume exactly it
                  acc   <= {{DW{1'b0}}, (is_w ? (mag1 << (DW - WW)) : mag1)};
                  state <= S_DIV_RUN;
               end
            end
            S_MUL_RUN: begin
               acc <= mul_next;
               b_q <= b_q >> 1;
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            S_DIV_RUN: begin
               acc <= div_next;
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            S_FIX: begin
               o_result      <= fix_res;
               o_div_by_zero <= dbz_q;
               o_done        <= 1'b1;
               state         <= S_DONE;
            end
            S_DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
